// File: rtl/jk_pkg.sv
// Shared J/K flip-flop drive codes and the next-state-to-J/K encoder used by
// counters built from jk_ff cells.
package jk_pkg;

    // {J, K} drive codes.
    localparam logic [1:0] JK_HOLD = 2'b00;
    localparam logic [1:0] JK_RST  = 2'b01;
    localparam logic [1:0] JK_SET  = 2'b10;
    localparam logic [1:0] JK_TGL  = 2'b11;

    // Excitation for one bit: moving from q to n. Never returns JK_TGL, so a
    // cell is only ever set, reset or held.
    function automatic logic [1:0] jk_encode(input logic q, input logic n);
        return {~q & n, q & ~n};
    endfunction

endpackage

// File: rtl/jk_ff.sv
// Single J/K flip-flop with synchronous active-high reset and complementary output.
module jk_ff
    import jk_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qb
);

    logic state_q;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= 1'b0;
        end else begin
            case ({j, k})
                JK_HOLD: state_q <= state_q;
                JK_RST:  state_q <= 1'b0;
                JK_SET:  state_q <= 1'b1;
                default: state_q <= ~state_q;
            endcase
        end
    end

    assign q  = state_q;
    assign qb = ~state_q;

endmodule

// File: rtl/jk_sync_counter.sv
// Synchronous up/down counter with clamped parallel load, built from one jk_ff
// per bit; tc is combinational, wrap is a registered one-cycle pulse.
module jk_sync_counter
    import jk_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int MAXV  = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAXV);

    logic [WIDTH-1:0] cnt_d;
    logic [WIDTH-1:0] ff_j;
    logic [WIDTH-1:0] ff_k;
    logic             wrap_d;
    logic             wrap_q;

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cnt_d = q;
        if (load) begin
            cnt_d = (d > MAX_Q) ? MAX_Q : d;
        end else if (en) begin
            if (up) begin
                cnt_d = (q == MAX_Q) ? '0 : q + WIDTH'(1);
            end else begin
                cnt_d = (q == '0) ? MAX_Q : q - WIDTH'(1);
            end
        end
    end

    always_comb begin
        ff_j = '0;
        ff_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {ff_j[i], ff_k[i]} = jk_encode(q[i], cnt_d[i]);
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : gen_bit
        jk_ff u_ff (
            .clk (clk),
            .rst (rst),
            .j   (ff_j[g]),
            .k   (ff_k[g]),
            .q   (q[g]),
            .qb  ()
        );
    end

    assign tc = (up & (q == MAX_Q)) | (~up & (q == '0));

    // A wrap only counts when the enabled step actually ran from the terminal value.
    assign wrap_d = en & ~load & tc;

    always_ff @(posedge clk) begin
        if (rst) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= wrap_d;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_jk_sync_counter.sv
// Randomized and directed bench for jk_sync_counter against an arithmetic model,
// run on a full-range (MAXV=15) and a clamped (MAXV=9) instance side by side.
module tb_jk_sync_counter;

    logic       clk = 1'b0;
    logic       rst, en, up, load;
    logic [3:0] d;
    logic [3:0] q15, q9;
    logic       tc15, tc9, wrap15, wrap9;

    int errors = 0;
    int checks = 0;

    int m_q15, m_q9;
    bit m_w15, m_w9;

    logic [3:0] tb_j, tb_k, tb_qb;

    always #5 clk = ~clk;

    jk_sync_counter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .q(q15), .tc(tc15), .wrap(wrap15)
    );

    jk_sync_counter #(.WIDTH(4), .MAXV(9)) dut9 (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .d(d),
        .q(q9), .tc(tc9), .wrap(wrap9)
    );

    for (genvar g = 0; g < 4; g++) begin : gen_peek
        assign tb_j[g]  = dut.gen_bit[g].u_ff.j;
        assign tb_k[g]  = dut.gen_bit[g].u_ff.k;
        assign tb_qb[g] = dut.gen_bit[g].u_ff.qb;
    end

    function automatic int next_q(int cq, int maxv, bit r, bit l, bit e, bit u, int dv);
        if (r) return 0;
        if (l) return (dv > maxv) ? maxv : dv;
        if (e) return u ? (cq + 1) % (maxv + 1) : (cq + maxv) % (maxv + 1);
        return cq;
    endfunction

    function automatic bit tc_of(int cq, int maxv, bit u);
        return (u && cq == maxv) || (!u && cq == 0);
    endfunction

    // One rising edge: advance the model, then look at the cell invariants.
    task automatic step();
        @(posedge clk);
        m_w15 = !rst && !load && en && tc_of(m_q15, 15, up);
        m_w9  = !rst && !load && en && tc_of(m_q9, 9, up);
        m_q15 = next_q(m_q15, 15, rst, load, en, up, int'(d));
        m_q9  = next_q(m_q9, 9, rst, load, en, up, int'(d));
        #1;
        checks++;
        if ((tb_j & tb_k) !== 4'b0) begin
            errors++;
            $display("FAIL jk_both_set: j=%b k=%b required j&k=0000", tb_j, tb_k);
        end
        checks++;
        if (tb_qb !== ~q15) begin
            errors++;
            $display("FAIL qb_compl: qb=%b q=%b required qb=%b", tb_qb, q15, ~q15);
        end
    endtask

    task automatic drive(bit r, bit l, bit e, bit u, logic [3:0] dv);
        rst = r; load = l; en = e; up = u; d = dv;
    endtask

    task automatic test_reset();
        drive(1, 0, 0, 1, 4'd0);
        step();
        checks++;
        if (q15 !== 4'd0 || wrap15 !== 1'b0 || tc15 !== 1'b0) begin
            errors++;
            $display("FAIL reset_up: q=%0d wrap=%b tc=%b required 0 0 0", q15, wrap15, tc15);
        end
        up = 1'b0;
        #1;
        checks++;
        if (tc15 !== 1'b1 || tc9 !== 1'b1 || q9 !== 4'd0) begin
            errors++;
            $display("FAIL reset_down_tc: tc=%b tc9=%b q9=%0d required 1 1 0", tc15, tc9, q9);
        end
    endtask

    task automatic test_up_wrap();
        drive(1, 0, 0, 1, 4'd0);
        step();
        drive(0, 0, 1, 1, 4'd0);
        for (int k = 1; k <= 17; k++) begin
            step();
            checks++;
            if (q15 !== 4'(k % 16) || wrap15 !== (k == 16)) begin
                errors++;
                $display("FAIL up_wrap edge %0d: q=%0d wrap=%b required %0d %b",
                         k, q15, wrap15, k % 16, k == 16);
            end
        end
    endtask

    task automatic test_down_wrap();
        drive(1, 0, 0, 0, 4'd0);
        step();
        drive(0, 0, 1, 0, 4'd0);
        #1;
        checks++;
        if (tc15 !== 1'b1) begin
            errors++;
            $display("FAIL down_tc_at_0: tc=%b required 1", tc15);
        end
        step();
        checks++;
        if (q15 !== 4'd15 || wrap15 !== 1'b1 || tc15 !== 1'b0) begin
            errors++;
            $display("FAIL down_wrap: q=%0d wrap=%b tc=%b required 15 1 0", q15, wrap15, tc15);
        end
        step();
        checks++;
        if (q15 !== 4'd14 || wrap15 !== 1'b0) begin
            errors++;
            $display("FAIL down_after_wrap: q=%0d wrap=%b required 14 0", q15, wrap15);
        end
    endtask

    task automatic test_load_clamp();
        drive(1, 0, 0, 1, 4'd0);
        step();
        drive(0, 1, 0, 1, 4'd12);
        step();
        checks++;
        if (q9 !== 4'd9 || q15 !== 4'd12 || tc9 !== 1'b1) begin
            errors++;
            $display("FAIL load_clamp: q9=%0d q15=%0d tc9=%b required 9 12 1", q9, q15, tc9);
        end
        drive(0, 0, 1, 1, 4'd0);
        step();
        checks++;
        if (q9 !== 4'd0 || wrap9 !== 1'b1 || q15 !== 4'd13 || wrap15 !== 1'b0) begin
            errors++;
            $display("FAIL clamp_wrap: q9=%0d wrap9=%b q15=%0d wrap15=%b required 0 1 13 0",
                     q9, wrap9, q15, wrap15);
        end
    endtask

    task automatic test_load_priority();
        drive(0, 1, 0, 1, 4'd15);
        step();
        drive(0, 1, 1, 1, 4'd5);
        step();
        checks++;
        if (q15 !== 4'd5 || wrap15 !== 1'b0 || q9 !== 4'd5 || wrap9 !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: q=%0d wrap=%b q9=%0d wrap9=%b required 5 0 5 0",
                     q15, wrap15, q9, wrap9);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 1, 0, 1, 4'd7);
        step();
        drive(0, 0, 1, 1, 4'd0);
        step();
        drive(1, 0, 1, 1, 4'd3);
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (q15 !== 4'd0 || wrap15 !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid edge %0d: q=%0d wrap=%b required 0 0", k, q15, wrap15);
            end
        end
        drive(0, 0, 1, 1, 4'd0);
        for (int k = 1; k <= 2; k++) begin
            step();
            checks++;
            if (q15 !== 4'(k)) begin
                errors++;
                $display("FAIL resume %0d: q=%0d required %0d", k, q15, k);
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 24) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                  4'($urandom_range(0, 15)));
            step();
            checks++;
            if (q15 !== 4'(m_q15) || wrap15 !== m_w15 || tc15 !== tc_of(m_q15, 15, up)) begin
                errors++;
                $display("FAIL rand15 #%0d: q=%0d wrap=%b tc=%b required %0d %b %b",
                         n, q15, wrap15, tc15, m_q15, m_w15, tc_of(m_q15, 15, up));
            end
            checks++;
            if (q9 !== 4'(m_q9) || wrap9 !== m_w9 || tc9 !== tc_of(m_q9, 9, up)) begin
                errors++;
                $display("FAIL rand9 #%0d: q=%0d wrap=%b tc=%b required %0d %b %b",
                         n, q9, wrap9, tc9, m_q9, m_w9, tc_of(m_q9, 9, up));
            end
        end
    endtask

    initial begin
        drive(1, 0, 0, 1, 4'd0);
        m_q15 = 0;
        m_q9  = 0;
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_load_priority();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_sync_counter.md
JK_SYNC_COUNTER -- requirements
Module: jk_sync_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 4: counter bit width, legal range 2..8.
REQ-002 SHALL have parameter MAXV, default 2**WIDTH-1: terminal count value; the count sequence is 0..MAXV, with MAXV at least 1.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: count enable.
REQ-006 SHALL have port up, input, 1 bit: direction; 1 counts up, 0 counts down.
REQ-007 SHALL have port load, input, 1 bit: synchronous parallel load strobe.
REQ-008 SHALL have port d, input, WIDTH bits: load value.
REQ-009 SHALL have port q, output, WIDTH bits: current count, taken directly from the flip-flop q outputs.
REQ-010 SHALL have port tc, output, 1 bit: terminal count, combinational.
REQ-011 SHALL have port wrap, output, 1 bit: registered one-cycle pulse that flags a completed wrap-around.

Function
REQ-012 SHALL apply update priority per rising edge as rst > load > en > hold.
REQ-013 SHALL, on load, set q to d on the next edge; if d > MAXV, q SHALL take MAXV.
REQ-014 SHALL, with en=1 and up=1, go to q+1, or to 0 when q==MAXV.
REQ-015 SHALL, with en=1 and up=0, go to q-1, or to MAXV when q==0.
REQ-016 SHALL hold q with en=0 and load=0, driving every bit with J=0, K=0.
REQ-017 SHALL derive the J/K drive from next state n: J[i] = ~q[i] & n[i], K[i] = q[i] & ~n[i]; it SHALL never drive J=K=1.
REQ-018 SHALL use one-edge latency: inputs sampled at edge N appear on q after edge N.
REQ-019 SHALL assert tc = (up & q==MAXV) | (~up & q==0), regardless of en.
REQ-020 SHALL assert wrap for exactly one cycle after an edge on which en=1, load=0, rst=0 and tc=1.
REQ-021 SHALL NOT assert wrap when a load or reset occurs while tc=1.
REQ-022 SHALL let a direction change take effect on the very next enabled edge, with no extra step.
REQ-023 SHALL NOT affect q through a simultaneous load=1 and en=1; only the load is applied, and wrap SHALL stay 0.

Reset
REQ-024 SHALL, on an edge with rst=1, set q=0 and wrap=0; tc then follows REQ-019 (1 if up=0).
REQ-025 SHALL abandon any pending load or count when rst is asserted mid-operation.
REQ-026 SHALL resume counting from 0 on the first edge after rst falls.
REQ-027 SHALL NOT use any asynchronous reset path.

Structure
REQ-028 SHALL build each of the WIDTH state bits from one instance of the existing jk_ff sub-module, sharing clk and rst.
REQ-029 SHALL leave each instance's qb output unconnected, except where verification checks it.
REQ-030 SHALL hold the wrap flag in a plain register outside the jk_ff instances.
REQ-031 SHALL place the J/K code constants in the shared package jk_pkg: JK_HOLD=2'b00, JK_RST=2'b01, JK_SET=2'b10, JK_TGL=2'b11.
REQ-032 SHALL also place a next-state-to-JK encode function in jk_pkg, for reuse by other counters.
REQ-033 SHALL use no other sub-modules.

Verification
REQ-034 SHALL cover up-count wrap: rst, then en=1 up=1 for 17 edges at WIDTH=4 -> q runs 0..15, then 0, and wrap is high for exactly the cycle after 15->0.
REQ-035 SHALL cover down-count wrap: rst, then en=1 up=0 -> q goes 0->15->14, tc=1 while q==0, and wrap pulses once.
REQ-036 SHALL cover load with clamp: MAXV=9, load d=12 -> q=9; en=1 up=1 -> q=0 and wrap=1.
REQ-037 SHALL cover load priority: load=1 en=1 d=5 from q=15 with up=1 -> q=5 and wrap=0.
REQ-038 SHALL cover reset mid-count: q=7 counting, rst held 2 edges -> q=0, wrap=0, and count resumes 1,2 after release.
REQ-039 SHALL check on every edge that J and K are never both 1 on any bit, and that each qb equals ~q.
